wstream_adapter: RTL and testbench



---
 rtl/wstream_adapter_pkg.sv | 6 +
 rtl/wstream_adapter_sat_counter.sv | 17 +
 rtl/wstream_adapter.sv | 63 ++++++
 tb/tb_wstream_adapter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/wstream_adapter_pkg.sv
// wstream_adapter_pkg: occupancy encoding and default widths shared by the write-side adapter
package wstream_adapter_pkg;
  localparam int DWIDTH_DEF = 8;
  localparam int CWIDTH_DEF = 16;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;
endpackage

// File: rtl/wstream_adapter_sat_counter.sv
// sat_counter: counter that increments on inc_i, holds at all-ones, clears on clr_i or async reset
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q, q_d;
  always_comb q_d = clr_i ? '0 : (inc_i && q_q != '1) ? q_q + 1'b1 : q_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/wstream_adapter.sv
// wstream_adapter: two-entry skid buffer between a valid/ready producer and the FIFO write port,
// with committed-word and full-stall statistics
module wstream_adapter
  import wstream_adapter_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int CWIDTH = CWIDTH_DEF
) (
  input  logic              wclk_i,
  input  logic              arst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DWIDTH-1:0] s_data_i,
  input  logic              wfull_i,
  output logic              wdv_o,
  output logic [DWIDTH-1:0] wdata_o,
  output logic [CWIDTH-1:0] wr_count_o,
  output logic [CWIDTH-1:0] stall_count_o
);
  occ_e              occ_q, occ_d;
  logic [DWIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic              s_ready_q, wdv_q, acc, com;
  logic [CWIDTH-1:0] wr_q;
  assign acc = s_valid_i && s_ready_q;
  assign com = wdv_q && !wfull_i;
  always_comb begin
    occ_d  = occ_q == EMPTY ? (acc ? ONE : EMPTY)
           : occ_q == ONE   ? (acc && !com ? TWO : !acc && com ? EMPTY : ONE)
           : (com ? ONE : TWO);
    // acc never happens in TWO, so a fresh word goes to HEAD whenever HEAD is free or leaving
    head_d = acc && (occ_q == EMPTY || com) ? s_data_i
           : (occ_q == TWO && com)          ? tail_q
           : head_q;
    tail_d = acc && occ_q == ONE && !com ? s_data_i : tail_q;
  end
  always_ff @(posedge wclk_i or posedge arst_i)
    if (arst_i) begin
      occ_q     <= EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      s_ready_q <= 1'b0;
      wdv_q     <= 1'b0;
      wr_q      <= '0;
    end else begin
      occ_q     <= occ_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      s_ready_q <= occ_d != TWO;
      wdv_q     <= occ_d != EMPTY;
      wr_q      <= wr_q + CWIDTH'(com);
    end
  sat_counter #(.WIDTH(CWIDTH)) u_stall (
    .clk_i (wclk_i),
    .rst_i (arst_i),
    .inc_i (wdv_q && wfull_i),
    .clr_i (1'b0),
    .q_o   (stall_count_o)
  );
  assign s_ready_o  = s_ready_q;
  assign wdv_o      = wdv_q;
  assign wdata_o    = head_q;
  assign wr_count_o = wr_q;
endmodule

// File: tb/tb_wstream_adapter.sv
// tb_wstream_adapter: queue-model scoreboard plus directed scenarios for the write-side adapter
module tb_wstream_adapter;
  logic        clk = 1'b0, rst = 1'b1, s_valid = 1'b0, wfull = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, wdv;
  logic [7:0]  wdata;
  logic [15:0] wr_count, stall_count;
  int n_chk = 0, n_fail = 0;

  wstream_adapter dut (
    .wclk_i(clk), .arst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .wfull_i(wfull), .wdv_o(wdv), .wdata_o(wdata),
    .wr_count_o(wr_count), .stall_count_o(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain queue of buffered words; capacity two, ready whenever fewer than two are held
  logic [7:0]  mq[$];
  logic [7:0]  m_hist[$];
  bit          m_ready, m_a, m_c;
  logic [15:0] m_wr, m_stall;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); m_hist.delete(); m_ready = 0; m_wr = 0; m_stall = 0;
    end else begin
      m_a = s_valid && m_ready;
      m_c = mq.size() > 0 && !wfull;
      if (mq.size() > 0 && wfull && m_stall != 16'hFFFF) m_stall++;
      if (m_c) begin void'(mq.pop_front()); m_wr++; end
      if (m_a) begin mq.push_back(s_data); m_hist.push_back(s_data); end
      m_ready = mq.size() < 2;
    end
  end

  logic [7:0] dut_com[$];
  always @(negedge clk) begin
    chk("s_ready", s_ready, m_ready);
    chk("wdv", wdv, mq.size() > 0);
    chk("wr_count", wr_count, m_wr);
    chk("stall_count", stall_count, m_stall);
    if (rst) begin
      chk("wdata_rst", wdata, 0);
      dut_com.delete();
    end else if (mq.size() > 0) chk("wdata", wdata, mq[0]);
    if (!rst && wdv && !wfull) dut_com.push_back(wdata);
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_reset();
    rst = 1; s_valid = 0; wfull = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic send(input logic [7:0] w);
    int b = 0;
    s_valid = 1; s_data = w;
    while (!s_ready && b < 200) begin tick(); b++; end
    if (!s_ready) chk("send_timeout", s_ready, 1);
    tick();
  endtask

  task automatic drain();
    int b = 0;
    s_valid = 0;
    while (wdv && b < 300) begin tick(); b++; end
    chk("drain_wdv", wdv, 0);
  endtask

  initial begin
    bit saw_low, acc_now;
    // reset and release
    tick(); tick();
    chk("rst_ready", s_ready, 0);
    chk("rst_wdv", wdv, 0);
    chk("rst_wr", wr_count, 0);
    chk("rst_stall", stall_count, 0);
    rst = 0;
    #1 chk("ready_before_edge", s_ready, 0);
    tick();
    chk("ready_after_edge", s_ready, 1);
    chk("idle_wdv", wdv, 0);

    // back-to-back stream with no backpressure
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      send(8'(i));
      if (i == 1) begin
        chk("lat_wdv", wdv, 1);
        chk("lat_wdata", wdata, 8'h01);
      end
    end
    drain();
    chk("s2_wr", wr_count, 16);
    chk("s2_stall", stall_count, 0);
    chk("s2_len", dut_com.size(), 16);
    for (int i = 0; i < dut_com.size(); i++) chk("s2_word", dut_com[i], i + 1);

    // wfull pulse of 5 cycles after the third commit
    do_reset();
    saw_low = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i));
        s_valid = 0;
      end
      begin
        int b = 0;
        while (wr_count < 3 && b < 100) begin tick(); b++; end
        chk("s3_reach3", wr_count, 3);
        wfull = 1;
        for (int i = 0; i < 5; i++) begin tick(); if (!s_ready) saw_low = 1; end
        wfull = 0;
      end
    join
    drain();
    chk("s3_ready_dropped", saw_low, 1);
    chk("s3_stall", stall_count, 5);
    chk("s3_wr", wr_count, 8);
    chk("s3_len", dut_com.size(), 8);
    for (int i = 0; i < dut_com.size(); i++) chk("s3_word", dut_com[i], 32'hA0 + i);

    // stall counter saturation
    do_reset();
    wfull = 1;
    send(8'h77);
    s_valid = 0;
    repeat (65546) tick();
    chk("sat_stall", stall_count, 16'hFFFF);
    wfull = 0;
    drain();
    chk("sat_wr", wr_count, 1);
    chk("sat_word", dut_com[0], 8'h77);

    // random traffic; producer holds its word until accepted
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      acc_now = s_valid && s_ready;
      tick();
      if (acc_now || !s_valid) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data = 8'($urandom);
      end
      wfull = ($urandom_range(0, 3) == 0);
    end
    s_valid = 0; wfull = 0;
    tick();
    drain();
    chk("rnd_len", dut_com.size(), m_hist.size());
    for (int i = 0; i < dut_com.size() && i < m_hist.size(); i++) chk("rnd_word", dut_com[i], m_hist[i]);
    chk("rnd_wr", wr_count, 16'(dut_com.size()));

    // asynchronous reset while holding two words
    do_reset();
    wfull = 1;
    send(8'h11);
    send(8'h22);
    s_valid = 0;
    chk("two_wdv", wdv, 1);
    chk("two_ready", s_ready, 0);
    chk("two_stall", stall_count, 1);
    #2 rst = 1;
    #1;
    chk("arst_wdv", wdv, 0);
    chk("arst_ready", s_ready, 0);
    chk("arst_stall", stall_count, 0);
    chk("arst_wdata", wdata, 0);
    tick();
    rst = 0; wfull = 0;
    send(8'h55);
    drain();
    chk("arst_len", dut_com.size(), 1);
    chk("arst_first", dut_com[0], 8'h55);
    chk("arst_wr", wr_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
